// File: rtl/bcd_seq_converter.sv
// rtl/bcd_seq_converter.sv - sequential double-dabble binary-to-BCD converter
`timescale 1ns/1ps
module bcd_seq_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic                  busy
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0]    r_bcd;
  logic [BW-1:0]    r_bcd_out;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic             r_overflow;
  logic             r_out_valid;

  logic [BW-1:0]    w_bcd_adj;
  logic [BW-1:0]    w_bcd_shift;
  logic             w_carry;
  logic             w_last;

  // Shared correction stage: add 3 to every digit >= 5, then shift in the next binary MSB
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) begin
        w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
    end
    w_carry     = w_bcd_adj[BW-1];
    w_bcd_shift = {w_bcd_adj[BW-2:0], r_bin[WIDTH-1]};
    w_last      = (r_cnt == CW'(1));
  end

  // Handshake FSM and shift datapath; the carry out of the top digit is sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_bcd_out   <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_bin   <= bin_in;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= CW'(WIDTH);
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_bcd <= w_bcd_shift;
          r_bin <= r_bin << 1;
          r_ovf <= r_ovf | w_carry;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_bcd_out   <= w_bcd_shift;
            r_overflow  <= r_ovf | w_carry;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_CONV);
  assign out_valid = r_out_valid;
  assign bcd_out   = r_bcd_out;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb/tb_bcd_seq_converter.sv - scoreboard bench for bcd_seq_converter
`timescale 1ns/1ps
module tb_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        rst_n;

  // main instance: WIDTH=8, DIGITS=3
  logic        in_valid, in_ready, out_valid, out_ready, overflow, busy;
  logic [7:0]  bin_in;
  logic [11:0] bcd_out;

  // wide instance: WIDTH=16, DIGITS=5
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_overflow, a_busy;
  logic [15:0] a_bin_in;
  logic [19:0] a_bcd_out;

  // narrow instance: WIDTH=8, DIGITS=2
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_overflow, b_busy;
  logic [7:0]  b_bin_in;
  logic [7:0]  b_bcd_out;

  int          n_vec = 0;
  int          n_err = 0;
  logic [12:0] sb[$];

  always #5 clk = ~clk;

  bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .bin_in(bin_in), .out_valid(out_valid), .out_ready(out_ready),
    .bcd_out(bcd_out), .overflow(overflow), .busy(busy)
  );

  bcd_seq_converter #(.WIDTH(16), .DIGITS(5)) u_dut_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .bin_in(a_bin_in), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .bcd_out(a_bcd_out), .overflow(a_overflow), .busy(a_busy)
  );

  bcd_seq_converter #(.WIDTH(8), .DIGITS(2)) u_dut_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .bin_in(b_bin_in), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .bcd_out(b_bcd_out), .overflow(b_overflow), .busy(b_busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: {overflow, three decimal digits} by repeated division
  function automatic logic [12:0] model3(input int v);
    int t;
    logic [11:0] b;
    t = v;
    b = '0;
    for (int i = 0; i < 3; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return {(t != 0), b};
  endfunction

  // result checker: every handover is compared with the oldest pending expectation
  always @(negedge clk) begin
    logic [12:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_val("sb_spurious_output", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("bcd_out", {20'd0, bcd_out}, {20'd0, e[11:0]});
        check_val("overflow", {31'd0, overflow}, {31'd0, e[12]});
      end
    end
  end

  task automatic send(input int v);
    int k;
    in_valid = 1'b1;
    bin_in   = 8'(v);
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 40) check_val("send_timeout", 32'd0, 32'd1);
    sb.push_back(model3(v));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 60; k++) begin
      if (sb.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    if (k == 60) check_val("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic conv_d2(input int v, input logic [7:0] eb, input logic eo);
    int k;
    int lat;
    b_in_valid = 1'b1;
    b_bin_in   = 8'(v);
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (b_in_ready) break;
    end
    if (k == 40) check_val("d2_send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (b_out_valid) begin
        lat = i;
        break;
      end
    end
    check_val("d2_latency", 32'(lat), 32'd8);
    check_val("d2_bcd", {24'd0, b_bcd_out}, {24'd0, eb});
    check_val("d2_overflow", {31'd0, b_overflow}, {31'd0, eo});
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    in_valid = 1'b0; bin_in = '0; out_ready = 1'b1;
    a_in_valid = 1'b0; a_bin_in = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_bin_in = '0; b_out_ready = 1'b1;

    // reset state
    #12;
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_bcd_out", {20'd0, bcd_out}, 32'd0);
    check_val("rst_overflow", {31'd0, overflow}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 255: latency is exactly WIDTH cycles after the accept edge
    send(255);
    wait_valid(lat);
    check_val("latency_255", 32'(lat), 32'd8);
    drain();

    // 0 then 99 back to back; in_ready low while converting
    send(0);
    check_val("busy_conv", {31'd0, busy}, 32'd1);
    check_val("in_ready_conv", {31'd0, in_ready}, 32'd0);
    send(99);
    drain();

    // backpressure on 128: result held, no new input accepted
    out_ready = 1'b0;
    send(128);
    wait_valid(lat);
    check_val("latency_128", 32'(lat), 32'd8);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_val("bp_bcd_hold", {20'd0, bcd_out}, 32'h128);
      check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_val("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("handover_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("handover_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("handover_bcd_kept", {20'd0, bcd_out}, 32'h128);
    drain();

    // in-flight change of bin_in with in_valid held high
    in_valid = 1'b1;
    bin_in   = 8'd42;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    sb.push_back(model3(42));
    @(posedge clk);
    #1 bin_in = 8'd7;
    @(posedge clk);
    #1;
    check_val("inflight_in_ready", {31'd0, in_ready}, 32'd0);
    check_val("inflight_busy", {31'd0, busy}, 32'd1);
    begin
      int k;
      for (k = 0; k < 40; k++) begin
        @(negedge clk);
        if (in_ready) break;
      end
      if (k == 40) check_val("inflight_reaccept_timeout", 32'd0, 32'd1);
    end
    sb.push_back(model3(7));
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // reset in the middle of a conversion aborts it
    send(77);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    check_val("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("midrst_bcd_out", {20'd0, bcd_out}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(200);
    drain();

    // random operands back to back
    for (int r = 0; r < 12; r++) begin
      send(int'($urandom_range(0, 255)));
    end
    drain();

    // wide instance: 65535 in 16 cycles
    a_in_valid = 1'b1;
    a_bin_in   = 16'd65535;
    @(negedge clk);
    check_val("w16_in_ready", {31'd0, a_in_ready}, 32'd1);
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (a_out_valid) begin
        lat = i;
        break;
      end
    end
    check_val("w16_latency", 32'(lat), 32'd16);
    check_val("w16_bcd", {12'd0, a_bcd_out}, 32'h65535);
    check_val("w16_overflow", {31'd0, a_overflow}, 32'd0);

    // two-digit instance: overflow and exact fit
    conv_d2(200, 8'h00, 1'b1);
    conv_d2(99, 8'h99, 1'b0);
    conv_d2(100, 8'h00, 1'b1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
